// File: rtl/mac_tx_arbiter.sv
// Round-robin per-frame arbiter sharing the MAC TX byte port between two sources.
// Request in IDLE -> dvld one cycle later; sources stall until mac_tx_ack, then stream one byte per cycle.
module mac_tx_arbiter #(
  parameter int IFG_CYCLES  = 12,
  parameter int ACK_TIMEOUT = 64,
  parameter int MAX_LEN     = 1518,
  parameter bit JUMBO_EN    = 1'b0,
  parameter bit NO_GEN_CRC  = 1'b0
) (
  input  logic        not_tx_clk,
  input  logic        reset,
  input  logic [1:0]  src_req,
  input  logic [15:0] src_data,
  input  logic [1:0]  src_last,
  output logic [1:0]  src_gnt,
  output logic [1:0]  src_rd,
  output logic [1:0]  src_abort,
  output logic [7:0]  mac_tx_data,
  output logic        mac_tx_dvld,
  input  logic        mac_tx_ack,
  output logic        conf_tx_en,
  output logic        conf_tx_jumbo_en,
  output logic        conf_tx_no_gen_crc,
  output logic [15:0] frm_cnt0,
  output logic [15:0] frm_cnt1,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, WAIT_ACK, SEND, DONE, ABORT, GAP} state_t;

  localparam logic [7:0]  TO_LAST  = 8'(ACK_TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST = 8'(IFG_CYCLES - 1);
  localparam logic [13:0] LEN_LAST = 14'(MAX_LEN - 1);

  state_t      state;
  logic        rr_ptr;
  logic [13:0] byte_cnt;
  logic [7:0]  to_cnt;
  logic [7:0]  gap_cnt;
  logic        g;
  logic        pick;
  logic        cur_last;

  assign g        = src_gnt[1];
  assign cur_last = src_last[g];
  // rr_ptr holds the last winner, so a tie goes to the other source
  assign pick     = (&src_req) ? ~rr_ptr : src_req[1];

  always_comb begin
    case (src_gnt)
      2'b01:   mac_tx_data = src_data[7:0];
      2'b10:   mac_tx_data = src_data[15:8];
      default: mac_tx_data = 8'h00;
    endcase
  end

  always_comb begin
    src_rd = 2'b00;
    if (state == SEND || (state == WAIT_ACK && mac_tx_ack))
      src_rd = src_gnt;
  end

  always_ff @(posedge not_tx_clk or posedge reset) begin
    if (reset) begin
      conf_tx_en         <= 1'b0;
      conf_tx_jumbo_en   <= 1'b0;
      conf_tx_no_gen_crc <= 1'b0;
    end else begin
      conf_tx_en         <= 1'b1;
      conf_tx_jumbo_en   <= JUMBO_EN;
      conf_tx_no_gen_crc <= NO_GEN_CRC;
    end
  end

  always_ff @(posedge not_tx_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b1;
      src_gnt     <= 2'b00;
      src_abort   <= 2'b00;
      mac_tx_dvld <= 1'b0;
      err         <= 1'b0;
      frm_cnt0    <= 16'd0;
      frm_cnt1    <= 16'd0;
      byte_cnt    <= 14'd0;
      to_cnt      <= 8'd0;
      gap_cnt     <= 8'd0;
    end else begin
      src_abort <= 2'b00;
      err       <= 1'b0;
      case (state)
        IDLE: begin
          if (|src_req) begin
            src_gnt     <= pick ? 2'b10 : 2'b01;
            rr_ptr      <= pick;
            state       <= WAIT_ACK;
            mac_tx_dvld <= 1'b1;
            byte_cnt    <= 14'd0;
            to_cnt      <= 8'd0;
          end
        end
        WAIT_ACK: begin
          // ack takes priority over a timeout landing in the same cycle
          if (mac_tx_ack) begin
            byte_cnt <= 14'd1;
            if (cur_last) begin
              state       <= DONE;
              mac_tx_dvld <= 1'b0;
            end else begin
              state <= SEND;
            end
          end else if (to_cnt == TO_LAST) begin
            state       <= ABORT;
            mac_tx_dvld <= 1'b0;
            src_abort   <= src_gnt;
            err         <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        SEND: begin
          byte_cnt <= byte_cnt + 14'd1;
          if (cur_last) begin
            state       <= DONE;
            mac_tx_dvld <= 1'b0;
          end else if (byte_cnt == LEN_LAST) begin
            state       <= ABORT;
            mac_tx_dvld <= 1'b0;
            src_abort   <= src_gnt;
            err         <= 1'b1;
          end
        end
        DONE: begin
          if (g) frm_cnt1 <= frm_cnt1 + 16'd1;
          else   frm_cnt0 <= frm_cnt0 + 16'd1;
          src_gnt <= 2'b00;
          gap_cnt <= 8'd0;
          state   <= GAP;
        end
        ABORT: begin
          src_gnt <= 2'b00;
          gap_cnt <= 8'd0;
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) state <= IDLE;
          else                     gap_cnt <= gap_cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_tx_arbiter.sv
// Directed bench for mac_tx_arbiter: frame-scenario table plus reset sequences.
module tb_mac_tx_arbiter;

  logic        not_tx_clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  src_req = 2'b00;
  logic [15:0] src_data = 16'h0000;
  logic [1:0]  src_last = 2'b00;
  logic [1:0]  src_gnt, src_rd, src_abort;
  logic [7:0]  mac_tx_data;
  logic        mac_tx_dvld;
  logic        mac_tx_ack = 1'b0;
  logic        conf_tx_en, conf_tx_jumbo_en, conf_tx_no_gen_crc;
  logic [15:0] frm_cnt0, frm_cnt1;
  logic        err;

  always #5 not_tx_clk = ~not_tx_clk;

  mac_tx_arbiter dut (
    .not_tx_clk(not_tx_clk), .reset(reset),
    .src_req(src_req), .src_data(src_data), .src_last(src_last),
    .src_gnt(src_gnt), .src_rd(src_rd), .src_abort(src_abort),
    .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
    .conf_tx_en(conf_tx_en), .conf_tx_jumbo_en(conf_tx_jumbo_en),
    .conf_tx_no_gen_crc(conf_tx_no_gen_crc),
    .frm_cnt0(frm_cnt0), .frm_cnt1(frm_cnt1), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;

  // source model: frames left, frame length (0 = never marks last), byte position
  int s_left[2], s_len[2], s_pos[2];
  logic [1:0] rd_prev, ab_prev, last_prev;
  int ack_delay, wait_n;
  bit acked;

  int rd_n[2], ab_n[2];
  int dv_n, err_n, seq, low_run, min_gap, data_bad, hot_bad;
  bit seen_high;
  logic [1:0] prev_gnt;

  typedef struct {
    int len0, len1, nf0, nf1, delay;
    int e_rd0, e_rd1, e_dv, e_ab0, e_ab1, e_err, e_f0, e_f1, e_seq, e_gap;
  } vec_t;
  vec_t vecs[7];

  function automatic logic [7:0] exp_byte(input int i, input int pos);
    int t;
    t = pos * 7 + i * 101 + 3;
    return t[7:0];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      src_req[i]         = (s_left[i] > 0);
      src_data[8*i +: 8] = exp_byte(i, s_pos[i]);
      src_last[i]        = (s_len[i] != 0) && (s_pos[i] == s_len[i] - 1);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 2; i++) begin
      rd_n[i] = 0;
      ab_n[i] = 0;
    end
    dv_n = 0; err_n = 0; seq = 0; low_run = 0; min_gap = 9999;
    data_bad = 0; hot_bad = 0; seen_high = 0; prev_gnt = 2'b00;
  endtask

  // One clock: advance sources by what the DUT consumed, drive, then sample.
  task automatic tick();
    int gi;
    @(negedge not_tx_clk);
    for (int i = 0; i < 2; i++) begin
      if (ab_prev[i]) begin
        s_left[i]--; s_pos[i] = 0;
      end else if (rd_prev[i]) begin
        if (last_prev[i]) begin
          s_left[i]--; s_pos[i] = 0;
        end else begin
          s_pos[i]++;
        end
      end
    end
    drive();
    if (mac_tx_dvld && !acked) begin
      wait_n++;
      if (ack_delay != 0 && wait_n == ack_delay) begin
        mac_tx_ack = 1'b1; acked = 1'b1;
      end else begin
        mac_tx_ack = 1'b0;
      end
    end else begin
      mac_tx_ack = 1'b0;
      if (!mac_tx_dvld) begin
        acked = 1'b0; wait_n = 0;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (src_rd[i]) rd_n[i]++;
      if (src_abort[i]) ab_n[i]++;
    end
    if (err) err_n++;
    if (src_gnt == 2'b11) hot_bad++;
    if (mac_tx_dvld) begin
      dv_n++;
      gi = src_gnt[1] ? 1 : 0;
      if (src_gnt == 2'b00 || mac_tx_data != exp_byte(gi, s_pos[gi])) data_bad++;
      if (seen_high && low_run > 0 && low_run < min_gap) min_gap = low_run;
      seen_high = 1'b1;
      low_run = 0;
    end else if (seen_high) begin
      low_run++;
    end
    if (src_gnt != 2'b00 && prev_gnt == 2'b00) seq = seq * 4 + (src_gnt[1] ? 2 : 1);
    prev_gnt  = src_gnt;
    rd_prev   = src_rd;
    ab_prev   = src_abort;
    last_prev = src_last;
  endtask

  task automatic clear_model();
    mac_tx_ack = 1'b0; acked = 1'b0; wait_n = 0;
    rd_prev = 2'b00; ab_prev = 2'b00; last_prev = 2'b00;
    s_pos[0] = 0; s_pos[1] = 0;
  endtask

  task automatic assert_reset();
    @(negedge not_tx_clk);
    reset = 1'b1;
    clear_model();
    drive();
    #1;
  endtask

  task automatic release_reset();
    @(negedge not_tx_clk);
    reset = 1'b0;
    clear_stats();
  endtask

  task automatic run_until_drained(output bit ok);
    int cyc, tail;
    cyc = 0; tail = 0;
    while (tail < 20 && cyc < 6000) begin
      tick();
      cyc++;
      if (s_left[0] == 0 && s_left[1] == 0) tail++;
    end
    ok = (tail >= 20);
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    bit ok;
    s_len[0] = v.len0; s_len[1] = v.len1;
    s_left[0] = v.nf0; s_left[1] = v.nf1;
    ack_delay = v.delay;
    assert_reset();
    release_reset();
    run_until_drained(ok);
    chk($sformatf("v%0d_drained", idx), int'(ok), 1);
    chk($sformatf("v%0d_rd0", idx), rd_n[0], v.e_rd0);
    chk($sformatf("v%0d_rd1", idx), rd_n[1], v.e_rd1);
    chk($sformatf("v%0d_dvld_cycles", idx), dv_n, v.e_dv);
    chk($sformatf("v%0d_abort0", idx), ab_n[0], v.e_ab0);
    chk($sformatf("v%0d_abort1", idx), ab_n[1], v.e_ab1);
    chk($sformatf("v%0d_err", idx), err_n, v.e_err);
    chk($sformatf("v%0d_frm_cnt0", idx), int'(frm_cnt0), v.e_f0);
    chk($sformatf("v%0d_frm_cnt1", idx), int'(frm_cnt1), v.e_f1);
    chk($sformatf("v%0d_grant_seq", idx), seq, v.e_seq);
    chk($sformatf("v%0d_min_gap", idx), min_gap, v.e_gap);
    chk($sformatf("v%0d_data_bad", idx), data_bad, 0);
    chk($sformatf("v%0d_gnt_onehot_bad", idx), hot_bad, 0);
  endtask

  initial begin
    bit ok;
    int cyc;
    // len0 len1 nf0 nf1 ackdly | rd0 rd1 dvld ab0 ab1 err f0 f1 seq gap
    vecs[0] = '{60, 0, 1, 0, 3,   60,   0,   62, 0, 0, 0, 1, 0,   1, 9999};
    vecs[1] = '{60, 60, 2, 2, 1,  120, 120,  240, 0, 0, 0, 2, 2, 102,   14};
    vecs[2] = '{60, 0, 1, 0, 0,    0,   0,   64, 1, 0, 1, 0, 0,   1, 9999};
    vecs[3] = '{0, 20, 0, 1, 64,   0,  20,   83, 0, 0, 0, 0, 1,   2, 9999};
    vecs[4] = '{0, 1, 0, 1, 2,     0,   1,    2, 0, 0, 0, 0, 1,   2, 9999};
    vecs[5] = '{0, 0, 0, 1, 1,     0, 1518, 1518, 0, 1, 1, 0, 0,  2, 9999};
    vecs[6] = '{60, 0, 2, 0, 0,    0,   0,  128, 2, 0, 2, 0, 0,   5,   14};

    // reset state
    s_left[0] = 0; s_left[1] = 0; s_len[0] = 0; s_len[1] = 0; ack_delay = 1;
    assert_reset();
    chk("rst_gnt", int'(src_gnt), 0);
    chk("rst_dvld", int'(mac_tx_dvld), 0);
    chk("rst_conf_en", int'(conf_tx_en), 0);
    chk("rst_frm_cnt0", int'(frm_cnt0), 0);
    chk("rst_frm_cnt1", int'(frm_cnt1), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_abort", int'(src_abort), 0);
    chk("rst_data", int'(mac_tx_data), 0);
    release_reset();
    tick();
    chk("conf_en_after_edge", int'(conf_tx_en), 1);
    chk("conf_jumbo", int'(conf_tx_jumbo_en), 0);
    chk("conf_no_crc", int'(conf_tx_no_gen_crc), 0);
    chk("idle_dvld", int'(mac_tx_dvld), 0);

    for (int k = 0; k < 7; k++) run_vector(vecs[k], k);

    // reset in the middle of the second frame from source 0
    s_len[0] = 60; s_len[1] = 0; s_left[0] = 2; s_left[1] = 0; ack_delay = 1;
    assert_reset();
    release_reset();
    cyc = 0;
    while (rd_n[0] < 90 && cyc < 1000) begin
      tick();
      cyc++;
    end
    chk("mid_rd_reached", rd_n[0], 90);
    chk("mid_frm_cnt0_before", int'(frm_cnt0), 1);
    chk("mid_dvld_before", int'(mac_tx_dvld), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_dvld", int'(mac_tx_dvld), 0);
    chk("mid_rst_gnt", int'(src_gnt), 0);
    chk("mid_rst_conf_en", int'(conf_tx_en), 0);
    chk("mid_rst_frm_cnt0", int'(frm_cnt0), 0);
    chk("mid_rst_abort", int'(src_abort), 0);
    chk("mid_rst_data", int'(mac_tx_data), 0);
    s_len[0] = 5; s_len[1] = 5; s_left[0] = 1; s_left[1] = 1;
    clear_model();
    drive();
    @(negedge not_tx_clk);
    reset = 1'b0;
    clear_stats();
    #1;
    chk("post_rst_conf_before_edge", int'(conf_tx_en), 0);
    tick();
    chk("post_rst_conf_en", int'(conf_tx_en), 1);
    chk("post_rst_first_gnt", int'(src_gnt), 1);
    chk("post_rst_dvld", int'(mac_tx_dvld), 1);
    run_until_drained(ok);
    chk("post_rst_drained", int'(ok), 1);
    chk("post_rst_frm_cnt0", int'(frm_cnt0), 1);
    chk("post_rst_frm_cnt1", int'(frm_cnt1), 1);
    chk("post_rst_grant_seq", seq, 6);
    chk("post_rst_data_bad", data_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
